// File: rtl/ck_input_conditioner_if.sv
// Bundle of raw request lines and conditioned outputs for the traffic-controller front end.
// The stimulus side drives RAW/CLR_STUCK; the conditioner drives everything else.
interface ck_input_conditioner_if;
    logic [2:0] RAW;
    logic [2:0] CLR_STUCK;
    logic       G0;
    logic       G1;
    logic       G2;
    logic [2:0] RISE;
    logic [2:0] STUCK;
    logic       FAULT;

    modport master (
        output RAW,
        output CLR_STUCK,
        input  G0,
        input  G1,
        input  G2,
        input  RISE,
        input  STUCK,
        input  FAULT
    );

    modport slave (
        input  RAW,
        input  CLR_STUCK,
        output G0,
        output G1,
        output G2,
        output RISE,
        output STUCK,
        output FAULT
    );
endinterface

// File: rtl/ck_input_conditioner.sv
// Three-channel synchronise/debounce/stuck-detect front end feeding the core's G0..G2 inputs.
// Every output leaves on a flop so the core only ever sees clean CK-domain levels.
module ck_input_conditioner #(
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 4,
    parameter int CNT_W       = 3,
    parameter int STUCK_MAX   = 255,
    parameter int STK_W       = 8
) (
    input  logic                   CK,
    input  logic                   RST,
    ck_input_conditioner_if.slave  bus
);

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE - 1);
    localparam logic [STK_W-1:0] STK_LIMIT = STK_W'(STUCK_MAX);

    logic [2:0] g_vec;
    logic [2:0] rise_vec;
    logic [2:0] stuck_vec;
    logic       fault_q;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_chan
            logic [SYNC_STAGES-1:0] sync_q;
            logic                   s;
            logic [CNT_W-1:0]       dcnt_q;
            logic [CNT_W-1:0]       dcnt_d;
            logic                   clean_q;
            logic                   clean_d;
            logic [STK_W-1:0]       scnt_q;
            logic [STK_W-1:0]       scnt_d;
            logic                   stuck_q;
            logic                   stuck_d;
            logic                   g_q;
            logic                   g_d;
            logic                   rise_q;

            assign s = sync_q[SYNC_STAGES-1];

            // The counter only advances while the synchronised level disagrees with the clean level.
            always_comb begin
                dcnt_d  = dcnt_q;
                clean_d = clean_q;
                if (s == clean_q) begin
                    dcnt_d = '0;
                end else if (dcnt_q == DEB_LAST) begin
                    clean_d = s;
                    dcnt_d  = '0;
                end else begin
                    dcnt_d = dcnt_q + CNT_W'(1);
                end
            end

            // A clear on the same edge as the limit being reached must win over the set.
            always_comb begin
                if (!clean_q) begin
                    scnt_d = '0;
                end else if (scnt_q == STK_LIMIT) begin
                    scnt_d = scnt_q;
                end else begin
                    scnt_d = scnt_q + STK_W'(1);
                end
                stuck_d = stuck_q | (scnt_d == STK_LIMIT);
                if (bus.CLR_STUCK[gi]) begin
                    scnt_d  = '0;
                    stuck_d = 1'b0;
                end
            end

            assign g_d = clean_q & ~stuck_q;

            always_ff @(posedge CK or posedge RST) begin
                if (RST) begin
                    sync_q  <= '0;
                    dcnt_q  <= '0;
                    clean_q <= 1'b0;
                    scnt_q  <= '0;
                    stuck_q <= 1'b0;
                    g_q     <= 1'b0;
                    rise_q  <= 1'b0;
                end else begin
                    sync_q  <= {sync_q[SYNC_STAGES-2:0], bus.RAW[gi]};
                    dcnt_q  <= dcnt_d;
                    clean_q <= clean_d;
                    scnt_q  <= scnt_d;
                    stuck_q <= stuck_d;
                    g_q     <= g_d;
                    rise_q  <= g_d & ~g_q;
                end
            end

            assign g_vec[gi]     = g_q;
            assign rise_vec[gi]  = rise_q;
            assign stuck_vec[gi] = stuck_q;
        end
    endgenerate

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= |stuck_vec;
        end
    end

    assign bus.G0    = g_vec[0];
    assign bus.G1    = g_vec[1];
    assign bus.G2    = g_vec[2];
    assign bus.RISE  = rise_vec;
    assign bus.STUCK = stuck_vec;
    assign bus.FAULT = fault_q;

endmodule

// File: tb/tb_ck_input_conditioner.sv
// Self-checking bench for ck_input_conditioner: scenario tasks plus randomized traffic against a history-based model.
module tb_ck_input_conditioner;

    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int SMAX = 255;
    // Edges from the first sampling edge to G: synchroniser, debounce, then the output flop.
    localparam int LAT  = SYNC + DEB + 1;

    logic       CK  = 1'b0;
    logic       RST = 1'b1;
    logic [2:0] raw = 3'b000;
    logic [2:0] clr = 3'b000;

    int tests = 0;
    int fails = 0;
    int lat_iso = 0;

    ck_input_conditioner_if bus ();
    assign bus.RAW       = raw;
    assign bus.CLR_STUCK = clr;

    ck_input_conditioner #(
        .SYNC_STAGES (SYNC),
        .DEBOUNCE    (DEB),
        .CNT_W       (3),
        .STUCK_MAX   (SMAX),
        .STK_W       (8)
    ) dut (
        .CK  (CK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CK = ~CK;

    // Reference model: sampled history of raw and synchronised levels, run-lengths for stuck detection.
    logic [2:0] hist[$];
    logic [2:0] shist[$];
    logic [2:0] m_clean, m_stuck, m_g, m_rise;
    logic       m_fault;
    int         m_hrun[3];

    wire  [9:0] obs   = {bus.G2, bus.G1, bus.G0, bus.RISE, bus.STUCK, bus.FAULT};
    wire  [9:0] exp_v = {m_g, m_rise, m_stuck, m_fault};

    task automatic model_reset();
        m_clean = '0; m_stuck = '0; m_g = '0; m_rise = '0; m_fault = 1'b0;
        hist.delete();
        shist.delete();
        for (int k = 0; k < SYNC; k++) hist.push_back(3'b000);
        for (int k = 0; k < DEB; k++) shist.push_back(3'b000);
        for (int i = 0; i < 3; i++) m_hrun[i] = 0;
    endtask

    task automatic model_step();
        logic [2:0] s_old, g_n, clean_n, stuck_n, e;
        int hr_n;
        bit flip;
        s_old = hist[SYNC-1];
        hist.push_front(raw);
        void'(hist.pop_back());
        shist.push_front(s_old);
        void'(shist.pop_back());
        g_n     = m_clean & ~m_stuck;
        m_fault = |m_stuck;
        m_rise  = g_n & ~m_g;
        m_g     = g_n;
        for (int i = 0; i < 3; i++) begin
            flip = 1'b1;
            for (int k = 0; k < DEB; k++) begin
                e = shist[k];
                if (e[i] == m_clean[i]) flip = 1'b0;
            end
            clean_n[i] = flip ? ~m_clean[i] : m_clean[i];
            hr_n = m_clean[i] ? ((m_hrun[i] + 1 > SMAX) ? SMAX : m_hrun[i] + 1) : 0;
            stuck_n[i] = m_stuck[i] | (hr_n == SMAX);
            if (clr[i]) begin
                hr_n = 0;
                stuck_n[i] = 1'b0;
            end
            m_hrun[i] = hr_n;
        end
        m_clean = clean_n;
        m_stuck = stuck_n;
    endtask

    always @(posedge CK or posedge RST) begin
        if (RST) model_reset();
        else     model_step();
    end

    task automatic cyc();
        @(posedge CK);
        #1;
    endtask

    task automatic test_reset();
        int first_g0 = 0;
        raw = 3'b111;
        RST = 1'b1;
        for (int n = 0; n < 3; n++) begin
            cyc();
            if (obs !== 10'b0) begin
                fails++;
                $display("FAIL reset_hold cyc%0d got=%b want=%b", n, obs, 10'b0);
            end
            tests++;
        end
        RST = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            cyc();
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL reset_release edge%0d got=%b want=%b", n, obs, exp_v);
            end
            tests++;
            if (bus.G0 && first_g0 == 0) begin
                first_g0 = n;
                if (bus.RISE[0] !== 1'b1) begin
                    fails++;
                    $display("FAIL reset_rise0 got=%b want=1", bus.RISE[0]);
                end
                tests++;
            end
        end
        if (first_g0 != LAT) begin
            fails++;
            $display("FAIL reset_g0_latency got=%0d want=%0d", first_g0, LAT);
        end
        tests++;
    endtask

    task automatic test_glitch();
        bit saw = 1'b0;
        int first_g1 = 0;
        raw = 3'b000;
        for (int n = 0; n < 12; n++) begin
            cyc();
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL glitch_settle cyc%0d got=%b want=%b", n, obs, exp_v);
            end
            tests++;
        end
        for (int n = 0; n < 15; n++) begin
            raw[1] = (n < 3);
            cyc();
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL glitch_pulse cyc%0d got=%b want=%b", n, obs, exp_v);
            end
            tests++;
            if (bus.G1 || bus.RISE[1]) saw = 1'b1;
        end
        if (saw) begin
            fails++;
            $display("FAIL glitch_reject got=G1/RISE1 seen want=none");
        end
        tests++;
        raw[1] = 1'b1;
        for (int n = 1; n <= 15; n++) begin
            cyc();
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL glitch_hold edge%0d got=%b want=%b", n, obs, exp_v);
            end
            tests++;
            if (bus.G1 && first_g1 == 0) first_g1 = n;
        end
        if (first_g1 != LAT) begin
            fails++;
            $display("FAIL glitch_g1_latency got=%0d want=%0d", first_g1, LAT);
        end
        tests++;
        lat_iso = first_g1;
    endtask

    task automatic test_stuck();
        int first_st = 0;
        raw[2] = 1'b1;
        for (int n = 1; n <= 300 && first_st == 0; n++) begin
            cyc();
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL stuck_run edge%0d got=%b want=%b", n, obs, exp_v);
            end
            tests++;
            if (bus.STUCK[2]) first_st = n;
        end
        if (first_st != SYNC + DEB + SMAX) begin
            fails++;
            $display("FAIL stuck_set_edge got=%0d want=%0d", first_st, SYNC + DEB + SMAX);
        end
        tests++;
        cyc();
        if ({bus.G2, bus.FAULT} !== 2'b01) begin
            fails++;
            $display("FAIL stuck_mask got=G2:%b FAULT:%b want=G2:0 FAULT:1", bus.G2, bus.FAULT);
        end
        tests++;
        clr[2] = 1'b1;
        cyc();
        clr[2] = 1'b0;
        if (bus.STUCK[2] !== 1'b0) begin
            fails++;
            $display("FAIL stuck_clear got=%b want=0", bus.STUCK[2]);
        end
        tests++;
        cyc();
        if ({bus.G2, bus.RISE[2]} !== 2'b11) begin
            fails++;
            $display("FAIL stuck_regrant got=G2:%b RISE2:%b want=1 1", bus.G2, bus.RISE[2]);
        end
        tests++;
        first_st = 0;
        for (int n = 2; n <= 300 && first_st == 0; n++) begin
            cyc();
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL stuck_rerun edge%0d got=%b want=%b", n, obs, exp_v);
            end
            tests++;
            if (bus.STUCK[2]) first_st = n;
        end
        if (first_st != SMAX) begin
            fails++;
            $display("FAIL stuck_reset_edge got=%0d want=%0d", first_st, SMAX);
        end
        tests++;
    endtask

    task automatic test_collision();
        bit hit = 1'b0;
        int n_after = 0;
        int first_st = 0;
        raw[0] = 1'b1;
        for (int n = 0; n < 600 && first_st == 0; n++) begin
            clr[0] = !hit && m_clean[0] && (m_hrun[0] == SMAX - 1);
            cyc();
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL collide_run cyc%0d got=%b want=%b", n, obs, exp_v);
            end
            tests++;
            if (hit) begin
                n_after++;
                if (bus.STUCK[0]) first_st = n_after;
            end
            if (clr[0]) begin
                hit = 1'b1;
                clr[0] = 1'b0;
                if (bus.STUCK[0] !== 1'b0) begin
                    fails++;
                    $display("FAIL collide_clear_wins got=%b want=0", bus.STUCK[0]);
                end
                tests++;
            end
        end
        clr[0] = 1'b0;
        if (first_st != SMAX) begin
            fails++;
            $display("FAIL collide_restart got=%0d want=%0d", first_st, SMAX);
        end
        tests++;
    endtask

    task automatic test_async_reset();
        raw[1] = 1'b0;
        for (int n = 0; n < 4; n++) begin
            cyc();
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL areset_pre cyc%0d got=%b want=%b", n, obs, exp_v);
            end
            tests++;
        end
        if (bus.STUCK[2] !== 1'b1) begin
            fails++;
            $display("FAIL areset_precond got=STUCK2:%b want=1", bus.STUCK[2]);
        end
        tests++;
        #2;
        RST = 1'b1;
        #1;
        if (obs !== 10'b0) begin
            fails++;
            $display("FAIL areset_immediate got=%b want=%b", obs, 10'b0);
        end
        tests++;
        cyc();
        raw = 3'b000;
        cyc();
        RST = 1'b0;
        for (int n = 0; n < 12; n++) begin
            cyc();
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL areset_post cyc%0d got=%b want=%b", n, obs, exp_v);
            end
            tests++;
        end
    endtask

    task automatic test_independence();
        int first_g1 = 0;
        raw[1] = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            cyc();
            raw[0] = n[1];
            if (obs !== exp_v || bus.G0 !== 1'b0) begin
                fails++;
                $display("FAIL indep edge%0d got=%b want=%b (G0 must stay 0)", n, obs, exp_v);
            end
            tests++;
            if (bus.G1 && first_g1 == 0) first_g1 = n;
        end
        if (first_g1 != lat_iso) begin
            fails++;
            $display("FAIL indep_g1_latency got=%0d want=%0d", first_g1, lat_iso);
        end
        tests++;
    endtask

    task automatic test_random();
        int hold = 0;
        for (int n = 0; n < 4000; n++) begin
            if (hold == 0) begin
                raw  = 3'($urandom_range(0, 7));
                hold = ($urandom_range(0, 15) == 0) ? $urandom_range(200, 320) : $urandom_range(1, 10);
            end
            hold--;
            clr = ($urandom_range(0, 40) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
            cyc();
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL random cyc%0d raw=%b clr=%b got=%b want=%b", n, raw, clr, obs, exp_v);
            end
            tests++;
        end
        clr = 3'b000;
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_stuck();
        test_collision();
        test_async_reset();
        test_independence();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
